// File: rtl/cmd_req_uart_if.sv
// Request handshake between the button command generator and its UART echo.
// Signals: req_rdy (level request), req_bus (8-bit code), req_ack (done pulse).
interface cmd_req_uart_if;
    logic       req_rdy;
    logic [7:0] req_bus;
    logic       req_ack;

    modport master (
        output req_rdy,
        output req_bus,
        input  req_ack
    );

    modport slave (
        input  req_rdy,
        input  req_bus,
        output req_ack
    );
endinterface

// File: rtl/cmd_req_uart.sv
// Echoes each command request as "R<hi><lo>\r\n" on an 8N1 UART TX pin.
// Ports: clk, rstz (async low), req (slave: req_rdy/req_bus in, req_ack out),
//        txd (serial out, idle high), busy (FSM not idle).
module cmd_req_uart #(
    parameter int unsigned BAUD_DIV = 104,
    parameter logic [7:0]  PREFIX   = 8'h52
) (
    input  logic          clk,
    input  logic          rstz,
    cmd_req_uart_if.slave req,
    output logic          txd,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAIT_CLR
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_CHAR = 3'd4;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  char_q, char_d;
    logic [7:0]  code_q, code_d;
    logic        abort_q, abort_d;
    logic        txd_q, txd_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;

    logic [7:0]  cur_char;
    logic [2:0]  bit_nx;
    logic        baud_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        cur_char = 8'h0A;
        unique case (char_q)
            3'd0:    cur_char = PREFIX;
            3'd1:    cur_char = hex_ascii(code_q[7:4]);
            3'd2:    cur_char = hex_ascii(code_q[3:0]);
            3'd3:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    assign bit_nx   = bit_q + 3'd1;
    assign baud_end = (cnt_q == BAUD_LAST);

    // txd/ack/busy are computed for the next state and registered, so the
    // pin changes on the same edge the FSM moves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        char_d  = char_q;
        code_d  = code_q;
        abort_d = abort_q;
        txd_d   = 1'b1;
        ack_d   = 1'b0;
        busy_d  = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req.req_rdy) begin
                    code_d  = req.req_bus;
                    char_d  = 3'd0;
                    cnt_d   = 16'd0;
                    abort_d = 1'b0;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_START: begin
                txd_d = 1'b0;
                if (!req.req_rdy) begin
                    abort_d = 1'b1;
                end
                if (baud_end) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    txd_d   = cur_char[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                txd_d = cur_char[bit_q];
                if (!req.req_rdy) begin
                    abort_d = 1'b1;
                end
                if (baud_end) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_nx;
                        txd_d = cur_char[bit_nx];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_STOP: begin
                txd_d = 1'b1;
                if (baud_end) begin
                    cnt_d = 16'd0;
                    // A dropped request anywhere in the frame skips the rest
                    if (abort_q || !req.req_rdy) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else if (char_q < LAST_CHAR) begin
                        char_d  = char_q + 3'd1;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_ACK: begin
                state_d = S_WAIT_CLR;
            end

            S_WAIT_CLR: begin
                // Held req_rdy must fall before another report can start
                if (!req.req_rdy) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            char_q  <= 3'd0;
            code_q  <= 8'd0;
            abort_q <= 1'b0;
            txd_q   <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            code_q  <= code_d;
            abort_q <= abort_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign txd         = txd_q;
    assign busy        = busy_q;
    assign req.req_ack = ack_q;

endmodule

// File: tb/tb_cmd_req_uart.sv
// Directed bench for cmd_req_uart: UART receiver feeds a byte scoreboard.
// Checks framing, hex mapping, ack timing, hold, snapshot, abort and reset.
module tb_cmd_req_uart;

    localparam int B = 4;

    logic clk;
    logic rstz;
    logic txd;
    logic busy;

    cmd_req_uart_if rif ();

    cmd_req_uart #(
        .BAUD_DIV(B),
        .PREFIX  (8'h52)
    ) dut (
        .clk (clk),
        .rstz(rstz),
        .req (rif.slave),
        .txd (txd),
        .busy(busy)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ack_cnt = 0;
    int         ack_cyc = 0;
    int         base = 0;
    bit         rst_flag = 0;
    logic [7:0] q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rif.req_ack === 1'b1) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
    end

    always @(negedge rstz) rst_flag = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        string s = "0123456789ABCDEF";
        return s[n];
    endfunction

    task automatic push_report(input logic [7:0] c);
        q.push_back(8'h52);
        q.push_back(hx(c[7:4]));
        q.push_back(hx(c[3:0]));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    // UART receiver: samples mid-bit on falling clock edges
    initial begin : rx_mon
        logic [7:0] rx;
        logic       st;
        logic       sp;
        logic [7:0] ex;
        forever begin
            @(negedge txd);
            rst_flag = 1'b0;
            repeat (B / 2) @(negedge clk);
            st = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(negedge clk);
                rx[i] = txd;
            end
            repeat (B) @(negedge clk);
            sp = txd;
            if (!rst_flag) begin
                chk("rx_start", 32'(st), 32'd0);
                chk("rx_stop", 32'(sp), 32'd1);
                checks++;
                assert (q.size() > 0)
                else begin
                    errors++;
                    $error("FAIL rx_extra: observed=%0h expected=none", rx);
                end
                if (q.size() > 0) begin
                    ex = q.pop_front();
                    chk("rx_char", 32'(rx), 32'(ex));
                end
            end
        end
    end

    task automatic wait_ack(input int prev, input string tag);
        int n = 0;
        while (ack_cnt == prev && n < 60 * B + 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, ack_cnt, prev + 1);
    endtask

    task automatic run_report(input logic [7:0] c, input string tag);
        int prev;
        prev = ack_cnt;
        push_report(c);
        rif.req_bus = c;
        @(negedge clk);
        rif.req_rdy = 1'b1;
        wait_ack(prev, tag);
        @(negedge clk);
        rif.req_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_q"}, q.size(), 32'd0);
    endtask

    initial begin
        int prev;
        rstz        = 1'b0;
        rif.req_rdy = 1'b0;
        rif.req_bus = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ack", 32'(rif.req_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstz = 1'b1;
        repeat (2) @(negedge clk);

        // Basic report with timing
        push_report(8'h3A);
        rif.req_bus = 8'h3A;
        @(negedge clk);
        rif.req_rdy = 1'b1;
        base = cyc;
        for (int i = 1; i <= B; i++) begin
            @(negedge clk);
            chk("start_low", 32'(txd), 32'd0);
        end
        chk("busy_on", 32'(busy), 32'd1);
        wait_ack(0, "ack1");
        chk("ack_cycle", ack_cyc - base, 50 * B + 1);
        @(negedge clk);
        chk("ack_single", 32'(rif.req_ack), 32'd0);
        rif.req_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_off", 32'(busy), 32'd0);
        chk("q_empty1", q.size(), 32'd0);

        // Hex boundaries
        run_report(8'h0F, "hex_0f");
        run_report(8'hF0, "hex_f0");
        run_report(8'h9A, "hex_9a");

        // Held req_rdy: one report only
        prev = ack_cnt;
        push_report(8'h3C);
        rif.req_bus = 8'h3C;
        @(negedge clk);
        rif.req_rdy = 1'b1;
        wait_ack(prev, "hold_ack");
        repeat (300) @(negedge clk);
        chk("hold_one_ack", ack_cnt, prev + 1);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_q", q.size(), 32'd0);
        rif.req_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_idle", 32'(busy), 32'd0);
        run_report(8'hC7, "second");

        // Snapshot: bus changes mid-report
        prev = ack_cnt;
        push_report(8'h12);
        rif.req_bus = 8'h12;
        @(negedge clk);
        rif.req_rdy = 1'b1;
        repeat (30) @(negedge clk);
        rif.req_bus = 8'h55;
        wait_ack(prev, "snap_ack");
        @(negedge clk);
        rif.req_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("snap_q", q.size(), 32'd0);

        // Abort during char 2, bit 3
        prev = ack_cnt;
        q.push_back(8'h52);
        q.push_back(hx(4'h6));
        q.push_back(hx(4'hB));
        rif.req_bus = 8'h6B;
        @(negedge clk);
        rif.req_rdy = 1'b1;
        repeat (98) @(negedge clk);
        rif.req_rdy = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_stop_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_txd", 32'(txd), 32'd1);
        repeat (100) @(negedge clk);
        chk("abort_no_ack", ack_cnt, prev);
        chk("abort_q", q.size(), 32'd0);

        // Reset during a data bit
        prev = ack_cnt;
        rif.req_bus = 8'h44;
        @(negedge clk);
        rif.req_rdy = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        rstz = 1'b0;
        #1;
        chk("rstmid_txd", 32'(txd), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        rif.req_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rstz = 1'b1;
        repeat (60) @(negedge clk);
        chk("rstmid_no_ack", ack_cnt, prev);
        chk("rstmid_q", q.size(), 32'd0);
        run_report(8'hA5, "post_rst");

        chk("final_q", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
